// File: rtl/alu_issue_fifo.sv
// Command FIFO between the issue stage and the ALU. Buffers {op, a, b} tuples
// in arrival order and presents the head entry directly to the ALU inputs.
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [DW-1:0]            in_a,
  input  logic [DW-1:0]            in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               op_code,
  output logic [DW-1:0]            a,
  output logic [DW-1:0]            b,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              issue_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;
  logic          push, pop;
  cmd_t          head;

  always_comb begin
    in_ready  = (count_q < FULL) && !flush;
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    head      = out_valid ? mem_q[rd_ptr_q] : '0;
  end

  // A pop in the flush cycle still counts as issued; flush only clears occupancy.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    issue_cnt_d = issue_cnt_q;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      issue_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= cmd_t'{op: in_op, a: in_a, b: in_b};
    end
  end

  assign op_code   = head.op;
  assign a         = head.a;
  assign b         = head.b;
  assign count     = count_q;
  assign issue_cnt = issue_cnt_q;

endmodule
